ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, enable 0xF4, reset 0xFF, …) from the port controller to the keyboard over the open-drain PS/2 clock/data pair. It is the outbound counterpart of the keyboard receive path that delivers `ps2_data`/`ps2_hit` to `portctl`. It sits beside that path, is driven by `portctl` on a CPU port write, and shares the physical PS/2 pins with it.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_sync.sv | 49 ++++
 rtl/ps2_tx.sv | 195 +++++++++++++++++++
 tb/tb_ps2_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
package ps2_pkg;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_state_e;

  // Width of the shared inhibit/timeout counter; 375000 cycles fits with margin.
  localparam int unsigned PS2_CNT_W = 24;

  // Keyboard command bytes issued by the port controller.
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

  // Convert a duration in microseconds to system clock cycles.
  function automatic int unsigned ps2_us_to_cyc(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

  // Cycles the clock line is held low before the start bit.
  function automatic int unsigned ps2_inhibit_cyc(input int unsigned clk_hz, input int unsigned us);
    return ps2_us_to_cyc(clk_hz, us);
  endfunction

  // Cycles allowed from clock release to the end of the frame.
  function automatic int unsigned ps2_timeout_cyc(input int unsigned clk_hz, input int unsigned us);
    return ps2_us_to_cyc(clk_hz, us);
  endfunction

  // Odd parity bit: makes the total number of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a falling-edge
// detector on the synchronized clock. Shared with the receive path.
module ps2_sync (
  input  logic clock,
  input  logic resetn,
  input  logic clk_i,
  input  logic dat_i,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_meta_q, dat_meta_d;
  logic dat_sync_q, dat_sync_d;

  // Next-state of the synchronizer chain and the edge-history flop.
  always_comb begin
    clk_meta_d = clk_i;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = dat_i;
    dat_sync_d = dat_meta_q;
  end

  // Registers reset to the idle (high) line level so no false edge appears.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  assign clk_s    = clk_sync_q;
  assign dat_s    = dat_sync_q;
  assign clk_fall = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first,
// odd parity, stop bit, then ACK clock and bus release.
// Optional build macro PS2_TX_ACK_EN: when defined, a missing ACK at the
// eleventh clock gives tx_error instead of tx_done.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_CYC = ps2_inhibit_cyc(CLK_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC  = ps2_timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam logic [PS2_CNT_W-1:0] INH_LAST = PS2_CNT_W'(INH_CYC - 32'd1);
  localparam logic [PS2_CNT_W-1:0] TO_LAST  = PS2_CNT_W'(TO_CYC - 32'd1);

  logic clk_s, dat_s, clk_fall;

  ps2_sync u_sync (
    .clock    (clock),
    .resetn   (resetn),
    .clk_i    (ps2_clk_i),
    .dat_i    (ps2_dat_i),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  ps2_state_e             state_q,  state_d;
  logic [PS2_CNT_W-1:0]   cnt_q,    cnt_d;
  logic [3:0]             bit_q,    bit_d;
  logic [9:0]             frame_q,  frame_d;   // {stop, parity, d7..d0}
  logic                   ack_q,    ack_d;
  logic                   busy_q,   busy_d;
  logic                   done_q,   done_d;
  logic                   error_q,  error_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   dat_oe_q, dat_oe_d;

  // Sequencing and output next-state; the timeout overrides every line-phase state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        // A request coinciding with the completion pulse is dropped.
        if (tx_start && !done_q && !error_q) begin
          frame_d  = {1'b1, ps2_odd_parity(tx_data), tx_data};
          cnt_d    = '0;
          ack_d    = 1'b0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_START;
        end else begin
          cnt_d = cnt_q + PS2_CNT_W'(1);
        end
      end

      ST_START: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        bit_d    = 4'd0;
        state_d  = ST_SHIFT;
      end

      ST_SHIFT: begin
        cnt_d = cnt_q + PS2_CNT_W'(1);
        if (clk_fall) begin
          dat_oe_d = ~frame_q[bit_q];
          bit_d    = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_ACK: begin
        cnt_d = cnt_q + PS2_CNT_W'(1);
        if (clk_fall) begin
`ifdef PS2_TX_ACK_EN
          ack_d = ~dat_s;
`else
          ack_d = 1'b1;
`endif
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_ACK;
        end
      end

      ST_RELEASE: begin
        cnt_d = cnt_q + PS2_CNT_W'(1);
        if (clk_s && dat_s) begin
          busy_d  = 1'b0;
          done_d  = ack_q;
          error_d = ~ack_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    if (((state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_RELEASE)) &&
        (cnt_q == TO_LAST)) begin
      busy_d   = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = ST_IDLE;
    end else begin
    end
  end

  // FSM state, counters and registered outputs; reset releases both lines at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      frame_q  <= 10'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural keyboard on open-drain pins, a scoreboard
// queue of expected frame outcomes and a monitor checking each done/error pulse.
// Run at a 1 MHz system clock so every timing scales down by 25.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned INHIBIT_US = 100;
  localparam int unsigned TIMEOUT_US = 15000;
  localparam int INH  = (CLK_HZ / 1_000_000) * INHIBIT_US;   // 100 cycles
  localparam int TO   = (CLK_HZ / 1_000_000) * TIMEOUT_US;   // 15000 cycles
  localparam int HALF = 40;                                  // 12.5 kHz device clock
  localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2, M_RESET = 3;

  typedef struct packed {
    logic       err;
    logic       has_frame;
    logic [9:0] frame;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low, dev_dat_low;
  wire        ps2_clk_pin = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_dat_pin = ~(ps2_dat_oe | dev_dat_low);

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       exp_q[$];
  logic [9:0] dev_frame;

  ps2_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (ps2_clk_pin),
    .ps2_dat_i  (ps2_dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference frame as the device should see it: data LSB first, odd parity, stop 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, p, b};
  endfunction

  // Monitor: every done/error pulse consumes one expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn && (tx_done || tx_error)) begin
        check("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
        if (exp_q.size() == 0) begin
          check("pulse_expected", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("result_is_error", {31'd0, tx_error}, {31'd0, e.err});
          if (e.has_frame) check("device_frame", {22'd0, dev_frame}, {22'd0, e.frame});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int mode, input bit busy_start, input bit done_start);
    exp_t        e;
    logic [9:0]  f;
    int          cnt, k;
    logic        last_dat, prev_dat;
    e.frame     = ref_frame(b);
    e.has_frame = (mode != M_SILENT);
`ifdef PS2_TX_ACK_EN
    e.err       = (mode != M_ACK);
`else
    e.err       = (mode == M_SILENT);
`endif
    if (mode != M_RESET) exp_q.push_back(e);

    @(negedge clock);
    tx_data  = b;
    tx_start = 1'b1;
    @(posedge clock);
    #1;
    tx_start = 1'b0;
    check("accept_busy_clk_oe", {30'd0, tx_busy, ps2_clk_oe}, 32'd3);

    // Measure how long the host holds the clock low and when it drives the start bit.
    cnt = 0; last_dat = 1'b0; prev_dat = 1'b0;
    while (cnt < INH + 50) begin
      @(negedge clock);
      if (!ps2_clk_oe) break;
      prev_dat = last_dat;
      last_dat = ps2_dat_oe;
      cnt++;
    end
    check("inhibit_length", cnt, INH + 1);
    check("start_bit_last_cycle_only", {30'd0, prev_dat, last_dat}, 32'd1);

    if (mode == M_SILENT) begin
      cnt = 0;
      while (cnt < 2 * TO) begin
        if (tx_error) break;
        cnt++;
        @(negedge clock);
      end
      check("timeout_cycles", cnt, TO);
      check("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      wait_cyc(20);
      return;
    end

    wait_cyc(HALF);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == 0 && b[0]) begin
        k = 0;
        while (k < 20) begin
          @(negedge clock);
          k++;
          if (!ps2_dat_oe) break;
        end
        check("bit_drive_latency", k, 3);
        wait_cyc(HALF - k);
      end else if (busy_start && i == 4) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        check("busy_mid_frame", {31'd0, tx_busy}, 32'd1);
        wait_cyc(HALF - 1);
      end else begin
        wait_cyc(HALF);
      end
      f[i] = ps2_dat_pin;
      dev_clk_low = 1'b0;
      wait_cyc(HALF);
      if (mode == M_RESET && i == 3) begin
        wait_cyc(5);
        check("busy_before_reset", {31'd0, tx_busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", {29'd0, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        wait_cyc(10);
        resetn = 1'b1;
        wait_cyc(10);
        return;
      end
    end

    // Eleventh clock: the device acknowledges by holding data low (unless told not to).
    dev_frame   = f;
    dev_dat_low = (mode == M_ACK);
    wait_cyc(HALF / 2);
    dev_clk_low = 1'b1;
    wait_cyc(HALF);
    dev_clk_low = 1'b0;
    wait_cyc(HALF / 2);
    dev_dat_low = 1'b0;

    if (mode == M_ACK) begin
      k = 0;
      while (k < 200) begin
        @(negedge clock);
        k++;
        if (tx_done || tx_error) break;
      end
      check("frame_end_latency", k, 3);
      check("busy_cleared_at_done", {31'd0, tx_busy}, 32'd0);
      if (done_start) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        check("start_at_done_dropped", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);
      end
    end
    wait_cyc(20);
  endtask

  initial begin
    resetn      = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_frame   = 10'd0;
    wait_cyc(5);
    check("reset_outputs",
          {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    resetn = 1'b1;
    wait_cyc(5);
    check("idle_outputs",
          {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd0);

    send(PS2_CMD_ENABLE, M_ACK, 1'b0, 1'b0);
    send(PS2_CMD_LEDS,   M_ACK, 1'b0, 1'b0);
    send(PS2_CMD_ENABLE, M_ACK, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      send(8'($urandom_range(0, 255)), M_ACK, 1'b0, (r == 1));
    end
    send(PS2_CMD_LEDS,   M_NOACK,  1'b0, 1'b0);
    send(8'h12,          M_SILENT, 1'b0, 1'b0);
    send(PS2_CMD_ENABLE, M_RESET,  1'b0, 1'b0);
    send(PS2_CMD_ENABLE, M_ACK,    1'b0, 1'b0);

    wait_cyc(50);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
